// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole input stage and the match logic that
// consumes its hit codes.
//   NUM_MOLES    number of mole buttons
//   HIT_NONE     hit code meaning "no hit this cycle"
//   state_e      hit encoder FSM state (2 bits)
//   idx_to_hit   button index (0-based) -> hit code (1-based mole number)
//   lowest_index index of the lowest set bit of an event vector
//   multi_hot    true when more than one bit of an event vector is set
// -----------------------------------------------------------------------------
package whack_pkg;

    localparam int NUM_MOLES = 5;
    localparam int HIT_W     = 3;

    localparam logic [HIT_W-1:0] HIT_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    // Mole i+1 is reported for button bit i; code 000 stays reserved for "none".
    function automatic logic [HIT_W-1:0] idx_to_hit(input logic [HIT_W-1:0] idx);
        return idx + 3'd1;
    endfunction

    // Lowest set bit wins arbitration; returns 0 for an empty vector.
    function automatic logic [HIT_W-1:0] lowest_index(input logic [NUM_MOLES-1:0] v);
        logic [HIT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_MOLES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = HIT_W'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [NUM_MOLES-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// The stable level only flips after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the
// count, so short glitches never move the output.
// Ports:
//   clock     system clock
//   reset     asynchronous, active-high; clears synchroniser, counter, level
//   raw_i     raw button, asynchronous to clock
//   stable_o  registered debounced level
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stb_q;
    logic             stb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stb_d = stb_q;
        cnt_d = cnt_q;
        if (sync2_q == stb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter clears at its terminal value rather than wrapping.
            stb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            stb_q <= stb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = stb_q;

endmodule

// File: rtl/whack_hit_encoder.sv
// -----------------------------------------------------------------------------
// whack_hit_encoder
// Input stage of the whack-a-mole datapath. Each raw mole button is
// synchronised and debounced; a rising edge of a debounced level is a press
// event. While armed, the lowest-numbered event becomes a one-cycle hit code
// (001..101) and starts a lockout during which further events are discarded.
// Dropped events are flagged with a one-cycle collision pulse.
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high; clears all state
//   enable      high while the game is in play; presses accepted only then
//   btn_raw     raw buttons, active-high, bit i = mole i+1
//   hit_code    registered hit code, non-zero for one cycle per accepted press
//   btn_stable  debounced button levels
//   locked      high while the lockout is running
//   collision   one-cycle pulse when press events were dropped
// -----------------------------------------------------------------------------
module whack_hit_encoder
    import whack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCKOUT_CYCLES  = 2500000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_MOLES-1:0] btn_raw,
    output logic [HIT_W-1:0]     hit_code,
    output logic [NUM_MOLES-1:0] btn_stable,
    output logic                 locked,
    output logic                 collision
);

    localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_MOLES-1:0] stb;
    logic [NUM_MOLES-1:0] stb_dly_q;
    logic [NUM_MOLES-1:0] ev;
    logic                 any_ev;
    logic                 multi_ev;
    logic [HIT_W-1:0]     win_idx;

    state_e               state_q;
    state_e               state_d;
    logic [LCK_W-1:0]     lock_cnt_q;
    logic [LCK_W-1:0]     lock_cnt_d;
    logic [HIT_W-1:0]     hit_code_q;
    logic [HIT_W-1:0]     hit_code_d;
    logic                 collision_q;
    logic                 collision_d;
    logic                 locked_q;
    logic                 locked_d;

    // One synchroniser + debouncer per mole button.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MOLES; gi++) begin : g_db
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clock   (clock),
                .reset   (reset),
                .raw_i   (btn_raw[gi]),
                .stable_o(stb[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stb_dly_q <= '0;
        end else begin
            stb_dly_q <= stb;
        end
    end

    // Only press edges count; releases are ignored. A held button therefore
    // produces exactly one event.
    assign ev       = stb & ~stb_dly_q;
    assign any_ev   = |ev;
    assign multi_ev = multi_hot(ev);
    assign win_idx  = lowest_index(ev);

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hit_code_d  = HIT_NONE;
        collision_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Events seen while idle are discarded, and flagged as such.
                collision_d = any_ev;
                if (enable) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (!enable) begin
                    // Disarming takes priority over a same-cycle event.
                    state_d     = IDLE;
                    collision_d = any_ev;
                end else if (any_ev) begin
                    hit_code_d  = idx_to_hit(win_idx);
                    lock_cnt_d  = LCK_LAST;
                    state_d     = LOCKOUT;
                    collision_d = multi_ev;
                end
            end

            LOCKOUT: begin
                collision_d = any_ev;
                if (!enable) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == '0) begin
                    state_d = ARMED;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase

        // Registered copy of the state decode keeps locked glitch-free.
        locked_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_cnt_q  <= '0;
            hit_code_q  <= HIT_NONE;
            collision_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            hit_code_q  <= hit_code_d;
            collision_q <= collision_d;
            locked_q    <= locked_d;
        end
    end

    assign hit_code   = hit_code_q;
    assign btn_stable = stb;
    assign locked     = locked_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_whack_hit_encoder.sv
// -----------------------------------------------------------------------------
// tb_whack_hit_encoder
// Directed scenarios with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8. Inputs are
// driven 1 ns after a rising edge; step t is the t-th edge after the stimulus
// of a scenario starts, and outputs are sampled 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_whack_hit_encoder;

    localparam int DB = 4;
    localparam int LK = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] btn_raw;
    logic [2:0] hit_code;
    logic [4:0] btn_stable;
    logic       locked;
    logic       collision;

    whack_hit_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .btn_raw   (btn_raw),
        .hit_code  (hit_code),
        .btn_stable(btn_stable),
        .locked    (locked),
        .collision (collision)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Per-scenario observations.
    int         hits;
    int         first_hit;
    int         last_hit_t;
    int         coll;
    int         first_coll;
    int         lk;
    int         first_stb;
    logic [2:0] first_val;
    logic [2:0] last_val;
    logic [4:0] watch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clr();
        hits       = 0;
        first_hit  = 0;
        last_hit_t = 0;
        coll       = 0;
        first_coll = 0;
        lk         = 0;
        first_stb  = 0;
        first_val  = 3'd0;
        last_val   = 3'd0;
    endtask

    task automatic step(input int t);
        @(posedge clock);
        #1;
        if (hit_code != 3'd0) begin
            hits++;
            if (first_hit == 0) begin
                first_hit = t;
                first_val = hit_code;
            end
            last_val   = hit_code;
            last_hit_t = t;
        end
        if (collision) begin
            coll++;
            if (first_coll == 0) first_coll = t;
        end
        if (locked) lk++;
        if (first_stb == 0 && (btn_stable & watch) != 5'd0) first_stb = t;
    endtask

    task automatic settle(input int n);
        btn_raw = 5'b00000;
        for (int i = 0; i < n; i++) step(0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        btn_raw = 5'b00000;
        watch   = 5'b00000;
        clr();
        step(0);
        step(0);
        check("rst_hit_code", 32'(hit_code), 0);
        check("rst_btn_stable", 32'(btn_stable), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_collision", 32'(collision), 0);
        reset = 1'b0;

        // Clean press of mole 3.
        enable = 1'b1;
        settle(3);
        clr();
        watch   = 5'b00100;
        btn_raw = 5'b00100;
        for (int t = 1; t <= 20; t++) step(t);
        check("clean_hits", hits, 1);
        check("clean_hit_step", first_hit, 7);
        check("clean_code", 32'(first_val), 3);
        check("clean_stb_step", first_stb, 6);
        check("clean_locked_cycles", lk, LK);
        check("clean_collisions", coll, 0);
        check("clean_btn_stable", 32'(btn_stable), 32'b00100);

        // Bounce on mole 1: toggles every 2 cycles for 12 cycles, then held.
        settle(20);
        clr();
        watch = 5'b00001;
        for (int t = 1; t <= 30; t++) begin
            btn_raw = (t <= 12 && (((t - 1) / 2) % 2) == 1) ? 5'b00000 : 5'b00001;
            step(t);
        end
        check("bounce_stb_step", first_stb, 18);
        check("bounce_hits", hits, 1);
        check("bounce_hit_step", first_hit, 19);
        check("bounce_code", 32'(first_val), 1);

        // Simultaneous press of moles 2 and 5.
        settle(20);
        clr();
        watch   = 5'b10010;
        btn_raw = 5'b10010;
        for (int t = 1; t <= 20; t++) step(t);
        check("simul_hits", hits, 1);
        check("simul_code", 32'(first_val), 2);
        check("simul_hit_step", first_hit, 7);
        check("simul_collisions", coll, 1);
        check("simul_coll_step", first_coll, 7);

        // Lockout: mole 1 hit, mole 5 debounced inside lockout, then again after.
        settle(20);
        clr();
        watch = 5'b00000;
        for (int t = 1; t <= 45; t++) begin
            if (t <= 6)       btn_raw = 5'b00001;
            else if (t <= 16) btn_raw = 5'b10000;
            else if (t <= 30) btn_raw = 5'b00000;
            else              btn_raw = 5'b10000;
            step(t);
        end
        check("lock_hits", hits, 2);
        check("lock_first_code", 32'(first_val), 1);
        check("lock_first_step", first_hit, 7);
        check("lock_collisions", coll, 1);
        check("lock_coll_step", first_coll, 13);
        check("lock_last_code", 32'(last_val), 5);
        check("lock_last_step", last_hit_t, 37);

        // Enable gating: press mole 3 while disabled, then enable while held.
        enable = 1'b0;
        settle(20);
        clr();
        watch   = 5'b00100;
        btn_raw = 5'b00100;
        for (int t = 1; t <= 15; t++) step(t);
        check("gate_hits", hits, 0);
        check("gate_collisions", coll, 1);
        check("gate_btn_stable", 32'(btn_stable), 32'b00100);
        enable = 1'b1;
        clr();
        for (int t = 1; t <= 10; t++) step(t);
        check("gate_held_hits", hits, 0);
        check("gate_held_collisions", coll, 0);
        check("gate_held_locked", lk, 0);

        // Enable boundary: event lands in the cycle enable is first sampled.
        enable = 1'b0;
        settle(20);
        clr();
        watch = 5'b01000;
        for (int t = 1; t <= 15; t++) begin
            btn_raw = 5'b01000;
            if (t == 7) enable = 1'b1;
            step(t);
        end
        check("edge_stb_step", first_stb, 6);
        check("edge_hits", hits, 0);
        check("edge_coll_step", first_coll, 7);

        // Reset during lockout with mole 2 held through it.
        settle(20);
        clr();
        watch   = 5'b00010;
        btn_raw = 5'b00010;
        for (int t = 1; t <= 9; t++) step(t);
        check("rlock_hit_step", first_hit, 7);
        check("rlock_locked_before", 32'(locked), 1);
        reset = 1'b1;
        #1;
        check("rlock_hit_code", 32'(hit_code), 0);
        check("rlock_btn_stable", 32'(btn_stable), 0);
        check("rlock_locked", 32'(locked), 0);
        check("rlock_collision", 32'(collision), 0);
        step(0);
        step(0);
        reset = 1'b0;
        clr();
        for (int t = 1; t <= 20; t++) step(t);
        check("rlock_stb_step", first_stb, 6);
        check("rlock_hits", hits, 1);
        check("rlock_hit_step2", first_hit, 7);
        check("rlock_code", 32'(first_val), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
